// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with a post-reset clear sweep, optional write bypass and read stall
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NREAD*ADDR_W-1:0]  raddr,
    input  logic                     stall,
    output logic [NREAD*DATA_W-1:0]  rdata,
    output logic                     busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [ADDR_W-1:0] ra [NREAD];
    logic [DATA_W-1:0] rd_nx [NREAD];
    logic              wr_ok;

    assign busy  = (state == CLEAR);
    assign wr_ok = we && !(ZERO_REG != 0 && waddr == '0);

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        assign ra[i]    = raddr[i*ADDR_W +: ADDR_W];
        assign rd_nx[i] = (ZERO_REG != 0 && ra[i] == '0) ? '0 :
                          (BYPASS != 0 && we && waddr == ra[i]) ? wdata : regs[ra[i]];
    end

    // next state: reset forces CLEAR; the sweep exits once, after its last entry
    always_comb begin
        state_nx = rst ? CLEAR : (state == CLEAR && &cnt) ? RUN : state;
    end

    // state register and sweep counter
    always_ff @(posedge clk) begin
        state <= state_nx;
        cnt   <= (rst || state != CLEAR) ? '0 : cnt + 1'b1;
    end

    // array update: sweep zeroes one entry per edge, normal writes only in RUN, nothing under reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                regs[cnt] <= '0;
            else if (wr_ok)
                regs[waddr] <= wdata;
        end
    end

    // read registers: zero under reset or sweep, held while stalled
    always_ff @(posedge clk) begin
        if (rst || state == CLEAR)
            rdata <= '0;
        else if (!stall)
            for (int k = 0; k < NREAD; k++)
                rdata[k*DATA_W +: DATA_W] <= rd_nx[k];
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed tests of regfile_mp in default, no-bypass and 4-port/8-entry configurations
module tb_regfile_mp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // default instance
    logic         rst0 = 1'b1, we0 = 1'b0, stall0 = 1'b0;
    logic [4:0]   waddr0 = '0;
    logic [31:0]  wdata0 = '0;
    logic [9:0]   raddr0 = '0;
    logic [63:0]  rdata0;
    logic         busy0;

    // BYPASS=0 instance
    logic         rst1 = 1'b1, we1 = 1'b0, stall1 = 1'b0;
    logic [4:0]   waddr1 = '0;
    logic [31:0]  wdata1 = '0;
    logic [9:0]   raddr1 = '0;
    logic [63:0]  rdata1;
    logic         busy1;

    // NREAD=4, ADDR_W=3 instance
    logic         rst2 = 1'b1, we2 = 1'b0, stall2 = 1'b0;
    logic [2:0]   waddr2 = '0;
    logic [31:0]  wdata2 = '0;
    logic [11:0]  raddr2 = '0;
    logic [127:0] rdata2;
    logic         busy2;

    regfile_mp u0 (
        .clk(clk), .rst(rst0), .we(we0), .waddr(waddr0), .wdata(wdata0),
        .raddr(raddr0), .stall(stall0), .rdata(rdata0), .busy(busy0)
    );

    regfile_mp #(.BYPASS(0)) u1 (
        .clk(clk), .rst(rst1), .we(we1), .waddr(waddr1), .wdata(wdata1),
        .raddr(raddr1), .stall(stall1), .rdata(rdata1), .busy(busy1)
    );

    regfile_mp #(.ADDR_W(3), .NREAD(4)) u2 (
        .clk(clk), .rst(rst2), .we(we2), .waddr(waddr2), .wdata(wdata2),
        .raddr(raddr2), .stall(stall2), .rdata(rdata2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst0 = 1'b1;
        tick();
        checks++;
        if (busy0 !== 1'b1 || rdata0 !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b rdata=%h, expected busy=1 rdata=0", busy0, rdata0);
        end
        rst0 = 1'b0;
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 32 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL sweep_len: busy dropped after %0d edges (busy=%b), expected 32", n, busy0);
        end
        for (int a = 0; a < 32; a += 2) begin
            raddr0 = {5'(a + 1), 5'(a)};
            tick();
            checks++;
            if (rdata0 !== 64'h0) begin
                errors++;
                $display("FAIL cleared_read[%0d]: got %h, expected 0", a, rdata0);
            end
        end
    endtask

    task automatic test_write_read();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; raddr0 = '0;
        tick();
        we0 = 1'b0; raddr0 = {5'd0, 5'd5};
        tick();
        checks++;
        if (rdata0 !== {32'h0, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL write_read: got %h, expected %h", rdata0, {32'h0, 32'hDEADBEEF});
        end
        raddr0 = {5'd5, 5'd5};
        tick();
        checks++;
        if (rdata0 !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL same_addr_ports: got %h, expected both DEADBEEF", rdata0);
        end
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h1; raddr0 = '0;
        tick();
        we0 = 1'b0; raddr0 = {5'd5, 5'd0};
        tick();
        checks++;
        if (rdata0 !== {32'hDEADBEEF, 32'h0}) begin
            errors++;
            $display("FAIL zero_reg: got %h, expected %h", rdata0, {32'hDEADBEEF, 32'h0});
        end
    endtask

    task automatic test_bypass();
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h12345678; raddr0 = {5'd7, 5'd5};
        tick();
        checks++;
        if (rdata0 !== {32'h12345678, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL bypass: got %h, expected %h", rdata0, {32'h12345678, 32'hDEADBEEF});
        end
        we0 = 1'b0; raddr0 = {5'd0, 5'd7};
        tick();
        checks++;
        if (rdata0 !== {32'h0, 32'h12345678}) begin
            errors++;
            $display("FAIL bypass_stored: got %h, expected %h", rdata0, {32'h0, 32'h12345678});
        end
    endtask

    task automatic test_bypass_off();
        int n;
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        n = 0;
        while (busy1 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 32 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL nobyp_sweep_len: %0d edges (busy=%b), expected 32", n, busy1);
        end
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'hAA;
        tick();
        wdata1 = 32'h12345678; raddr1 = {5'd7, 5'd0};
        tick();
        checks++;
        if (rdata1 !== {32'hAA, 32'h0}) begin
            errors++;
            $display("FAIL no_bypass: got %h, expected %h", rdata1, {32'hAA, 32'h0});
        end
        we1 = 1'b0;
        tick();
        checks++;
        if (rdata1 !== {32'h12345678, 32'h0}) begin
            errors++;
            $display("FAIL no_bypass_stored: got %h, expected %h", rdata1, {32'h12345678, 32'h0});
        end
    endtask

    task automatic test_stall();
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h11; raddr0 = '0;
        tick();
        we0 = 1'b0; raddr0 = {5'd0, 5'd9};
        tick();
        checks++;
        if (rdata0 !== 64'h11) begin
            errors++;
            $display("FAIL stall_pre: got %h, expected 11", rdata0);
        end
        stall0 = 1'b1; we0 = 1'b1; wdata0 = 32'h22;
        tick();
        checks++;
        if (rdata0 !== 64'h11) begin
            errors++;
            $display("FAIL stall_hold_write: got %h, expected 11", rdata0);
        end
        we0 = 1'b0;
        tick();
        checks++;
        if (rdata0 !== 64'h11) begin
            errors++;
            $display("FAIL stall_hold: got %h, expected 11", rdata0);
        end
        stall0 = 1'b0;
        tick();
        checks++;
        if (rdata0 !== 64'h22) begin
            errors++;
            $display("FAIL stall_release: got %h, expected 22", rdata0);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            if (e == 3) begin
                we0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'h55; raddr0 = {5'd1, 5'd1};
            end
            tick();
            if (e == 3) begin
                checks++;
                if (rdata0 !== 64'h0 || busy0 !== 1'b1) begin
                    errors++;
                    $display("FAIL sweep_ignores_we: rdata=%h busy=%b, expected 0 and 1", rdata0, busy0);
                end
                we0 = 1'b0;
            end
        end
        rst0 = 1'b1; stall0 = 1'b1;
        tick();
        checks++;
        if (busy0 !== 1'b1 || rdata0 !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset_state: busy=%b rdata=%h, expected 1 and 0", busy0, rdata0);
        end
        rst0 = 1'b0;
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL mid_reset_len: %0d edges, expected 32", n);
        end
        stall0 = 1'b0; raddr0 = {5'd9, 5'd1};
        tick();
        checks++;
        if (rdata0 !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset_cleared: got %h, expected 0", rdata0);
        end
    endtask

    task automatic test_nread4();
        int n;
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        n = 0;
        while (busy2 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 8 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL n4_sweep_len: %0d edges (busy=%b), expected 8", n, busy2);
        end
        for (int a = 1; a <= 4; a++) begin
            we2 = 1'b1; waddr2 = 3'(a); wdata2 = 32'(a);
            tick();
        end
        we2 = 1'b0; raddr2 = {3'd4, 3'd3, 3'd2, 3'd1};
        tick();
        checks++;
        if (rdata2 !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
            errors++;
            $display("FAIL n4_distinct: got %h, expected 4/3/2/1", rdata2);
        end
        raddr2 = {3'd1, 3'd2, 3'd3, 3'd4};
        tick();
        checks++;
        if (rdata2 !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
            errors++;
            $display("FAIL n4_reversed: got %h, expected 1/2/3/4", rdata2);
        end
        raddr2 = {3'd3, 3'd3, 3'd3, 3'd3};
        tick();
        checks++;
        if (rdata2 !== {32'd3, 32'd3, 32'd3, 32'd3}) begin
            errors++;
            $display("FAIL n4_same_addr: got %h, expected all 3", rdata2);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_bypass_off();
        test_stall();
        test_reset_mid_sweep();
        test_nread4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
